// File: rtl/sss_detector.sv
// ---------------------------------------------------------------------------
// sss_detector
//
// Captures a 62-bit secondary-synchronisation frame one bit at a time. It then
// scores the frame against the 31 cyclic shifts of a length-31 m-sequence, one
// candidate per clock. The best-matching shift is reported as n_id_2.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low reset
//   din         received frame bit; the first accepted bit is index n=0
//   din_valid   din is taken on an edge where din_valid=1 and busy=0
//   abort       synchronous discard of any capture/search in progress
//   busy        high while searching/reporting; din_valid is ignored then
//   done        one-cycle pulse after the result outputs have been updated
//   detected    best_score >= THRESHOLD for the latest result
//   n_id_2      index k (0..30) of the best-matching candidate
//   best_score  agreement count (0..62) of the best candidate
// ---------------------------------------------------------------------------
module sss_detector #(
    parameter int THRESHOLD = 56
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic       din_valid,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       detected,
    output logic [4:0] n_id_2,
    output logic [5:0] best_score
);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        SEARCH  = 2'd1,
        REPORT  = 2'd2
    } state_t;

    // Base sequence s(0..30) from x(i+5) = x(i+2) ^ x(i), x(0..4) = 0,0,0,0,1.
    // r holds x(i..i+4) with r[0] = x(i). s is filled from the top, so after
    // 31 steps x(0) sits in s[0].
    function automatic logic [30:0] gen_m_seq();
        logic [4:0]  r;
        logic [30:0] s;
        r = 5'b10000;
        s = '0;
        for (int i = 0; i < 31; i++) begin
            s = {r[0], s[30:1]};
            r = {r[2] ^ r[0], r[4:1]};
        end
        return s;
    endfunction

    // c_k[n] = s((n+k) mod 31) for n = 0..61. Bit n of the 31-bit
    // right-rotation by k is exactly s((n+k) mod 31). The 62-bit candidate is
    // two copies of that rotation.
    function automatic logic [61:0] gen_cand(input int k);
        logic [30:0] s;
        logic [30:0] rot;
        s   = gen_m_seq();
        rot = (s >> k) | (s << (31 - k));
        return {rot, rot};
    endfunction

    // Constant candidate table. Entry 31 is padding so that every value of the
    // 5-bit k index addresses a real entry.
    logic [61:0] cand_table [32];

    for (genvar gi = 0; gi < 32; gi++) begin : g_cand
        if (gi < 31) begin : g_valid
            assign cand_table[gi] = gen_cand(gi);
        end else begin : g_pad
            assign cand_table[gi] = '0;
        end
    end

    state_t      state_q,      state_d;
    logic [5:0]  cnt_q,        cnt_d;
    logic [4:0]  k_q,          k_d;
    logic [61:0] frame_q,      frame_d;
    logic [5:0]  run_score_q,  run_score_d;
    logic [4:0]  run_k_q,      run_k_d;
    logic [4:0]  n_id_2_q,     n_id_2_d;
    logic [5:0]  best_score_q, best_score_d;
    logic        detected_q,   detected_d;
    logic        done_q,       done_d;

    // Agreement score of the current candidate: popcount of XNOR. The sum is
    // 6 bits wide, because the maximum value 62 fits in 6 bits.
    logic [61:0] agree;
    logic [5:0]  score;

    always_comb begin
        agree = ~(frame_q ^ cand_table[k_q]);
        score = '0;
        for (int i = 0; i < 62; i++) begin
            score = score + {5'd0, agree[i]};
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        frame_d      = frame_q;
        run_score_d  = run_score_q;
        run_k_d      = run_k_q;
        n_id_2_d     = n_id_2_q;
        best_score_d = best_score_q;
        detected_d   = detected_q;
        done_d       = 1'b0;

        if (abort) begin
            // Result registers are left untouched. done_d stays 0, so a pending
            // report is dropped.
            state_d = CAPTURE;
            cnt_d   = '0;
            k_d     = '0;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (din_valid) begin
                        frame_d[cnt_q] = din;
                        cnt_d          = cnt_q + 6'd1;
                        if (cnt_q == 6'd61) begin
                            state_d     = SEARCH;
                            k_d         = '0;
                            run_score_d = '0;
                            run_k_d     = '0;
                        end
                    end
                end
                SEARCH: begin
                    // A strict compare keeps the lowest k on ties. The running
                    // best starts at 0, so an all-zero score never replaces it.
                    if (score > run_score_q) begin
                        run_score_d = score;
                        run_k_d     = k_q;
                    end
                    if (k_q == 5'd30) begin
                        state_d = REPORT;
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end
                REPORT: begin
                    n_id_2_d     = run_k_q;
                    best_score_d = run_score_q;
                    detected_d   = (run_score_q >= 6'(THRESHOLD));
                    done_d       = 1'b1;
                    state_d      = CAPTURE;
                    cnt_d        = '0;
                    k_d          = '0;
                end
                default: begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                    k_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CAPTURE;
            cnt_q        <= '0;
            k_q          <= '0;
            frame_q      <= '0;
            run_score_q  <= '0;
            run_k_q      <= '0;
            n_id_2_q     <= '0;
            best_score_q <= '0;
            detected_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            frame_q      <= frame_d;
            run_score_q  <= run_score_d;
            run_k_q      <= run_k_d;
            n_id_2_q     <= n_id_2_d;
            best_score_q <= best_score_d;
            detected_q   <= detected_d;
            done_q       <= done_d;
        end
    end

    assign busy       = (state_q != CAPTURE);
    assign done       = done_q;
    assign detected   = detected_q;
    assign n_id_2     = n_id_2_q;
    assign best_score = best_score_q;

endmodule

// File: tb/tb_sss_detector.sv
// ---------------------------------------------------------------------------
// tb_sss_detector
//
// Scoreboard bench for sss_detector. Each expected result is pushed when its
// frame is sent. A monitor pops and compares the expected result on every
// done pulse. A reference model derives candidates directly from the
// recurrence definition.
// ---------------------------------------------------------------------------
module tb_sss_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       abort;
    logic       busy;
    logic       done;
    logic       detected;
    logic [4:0] n_id_2;
    logic [5:0] best_score;

    always #5 clk = ~clk;

    sss_detector #(.THRESHOLD(56)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .detected   (detected),
        .n_id_2     (n_id_2),
        .best_score (best_score)
    );

    typedef struct {
        int k;
        int score;
        int det;
    } exp_t;

    exp_t sb_q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   done_count = 0;
    int   pushed     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit [30:0] ref_mseq();
        bit        x [0:35];
        bit [30:0] s;
        x[0] = 0; x[1] = 0; x[2] = 0; x[3] = 0; x[4] = 1;
        for (int i = 0; i < 31; i++) x[i+5] = x[i+2] ^ x[i];
        for (int i = 0; i < 31; i++) s[i] = x[i];
        return s;
    endfunction

    function automatic bit [61:0] ref_cand(input int k);
        bit [30:0] s;
        bit [61:0] c;
        s = ref_mseq();
        for (int n = 0; n < 62; n++) c[n] = s[(n + k) % 31];
        return c;
    endfunction

    function automatic exp_t ref_search(input bit [61:0] f);
        exp_t      e;
        bit [61:0] c;
        int        sc;
        e.k = 0;
        e.score = 0;
        for (int k = 0; k < 31; k++) begin
            c  = ref_cand(k);
            sc = 0;
            for (int n = 0; n < 62; n++) if (f[n] == c[n]) sc++;
            if (sc > e.score) begin
                e.score = sc;
                e.k     = k;
            end
        end
        e.det = (e.score >= 56) ? 1 : 0;
        return e;
    endfunction

    task automatic push_exp(input int k, input int score, input int det);
        exp_t e;
        e.k = k;
        e.score = score;
        e.det = det;
        sb_q.push_back(e);
        pushed++;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset === 1'b1 && done === 1'b1) begin
            done_count++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                $display("result n_id_2=%0d best_score=%0d detected=%0d (expect %0d/%0d/%0d)",
                         n_id_2, best_score, detected, e.k, e.score, e.det);
                chk("n_id_2", 32'(n_id_2), e.k);
                chk("best_score", 32'(best_score), e.score);
                chk("detected", 32'(detected), e.det);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input logic b);
        din       = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    task automatic send_frame(input bit [61:0] f, input int max_gap, input int nbits);
        int gap;
        for (int n = 0; n < nbits; n++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                din       = 1'($urandom);
                din_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_bit(f[n]);
        end
    endtask

    // Called just after the frame's last accepted edge E. done must be seen
    // right after E+32, and busy must be high at every edge before that.
    task automatic wait_result(input string tag, input bit toggle_inputs);
        int lat;
        int busy_low;
        bit seen;
        lat = 0;
        busy_low = 0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (toggle_inputs) begin
                din_valid = 1'($urandom);
                din       = 1'($urandom);
            end
            @(negedge clk);
            lat++;
            if (done === 1'b1) seen = 1;
            else if (busy !== 1'b1) busy_low++;
        end
        din_valid = 1'b0;
        din       = 1'b0;
        if (!seen) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_latency"}, lat, 33);
            chk({tag, "_busy_low"}, busy_low, 0);
            chk({tag, "_busy_at_done"}, 32'(busy), 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit [61:0] f;
        exp_t      e;
        int        flips8 [8] = '{3, 10, 17, 24, 31, 40, 50, 60};
        int        flips5 [5] = '{0, 13, 29, 44, 61};

        reset     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        abort     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_detected", 32'(detected), 0);
        chk("rst_n_id_2", 32'(n_id_2), 0);
        chk("rst_best_score", 32'(best_score), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Clean c_5, contiguous bits
        push_exp(5, 62, 1);
        send_frame(ref_cand(5), 0, 62);
        wait_result("c5", 0);

        // c_2 with 8 errors, then with 5 errors
        f = ref_cand(2);
        foreach (flips8[i]) f[flips8[i]] = ~f[flips8[i]];
        push_exp(2, 54, 0);
        send_frame(f, 0, 62);
        wait_result("c2_e8", 0);

        f = ref_cand(2);
        foreach (flips5[i]) f[flips5[i]] = ~f[flips5[i]];
        push_exp(2, 57, 1);
        send_frame(f, 0, 62);
        wait_result("c2_e5", 0);

        // All-zero frame: every candidate ties, so the lowest k must win
        e = ref_search('0);
        push_exp(e.k, e.score, e.det);
        send_frame('0, 0, 62);
        wait_result("zeros", 0);

        // Partial c_7, then abort (with din_valid also high), then gapped c_12
        send_frame(ref_cand(7), 0, 30);
        abort     = 1'b1;
        din_valid = 1'b1;
        din       = 1'b1;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        push_exp(12, 62, 1);
        send_frame(ref_cand(12), 3, 62);
        wait_result("c12_gaps", 0);

        // din_valid toggling during SEARCH must be ignored
        push_exp(9, 62, 1);
        send_frame(ref_cand(9), 0, 62);
        wait_result("c9_toggle", 1);

        // Reset near E+10 while searching c_3: no done, outputs cleared
        send_frame(ref_cand(3), 0, 62);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_detected", 32'(detected), 0);
        chk("midrst_n_id_2", 32'(n_id_2), 0);
        chk("midrst_best_score", 32'(best_score), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 0);
        push_exp(30, 62, 1);
        send_frame(ref_cand(30), 0, 62);
        wait_result("c30", 0);

        // Back-to-back c_0 then c_1; the second frame starts at E+33
        push_exp(0, 62, 1);
        send_frame(ref_cand(0), 0, 62);
        wait_result("c0_b2b", 0);
        push_exp(1, 62, 1);
        send_frame(ref_cand(1), 0, 62);
        wait_result("c1_b2b", 0);

        repeat (3) @(negedge clk);
        chk("done_count", done_count, pushed);
        chk("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
